// File: rtl/note_segmenter.sv
// Converts per-frame pitch estimates into debounced note events with a
// quantised (eighth/quarter/half/whole) duration and a one-cycle strobe.
module note_segmenter #(
  parameter int STABLE_FRAMES     = 3,
  parameter int RELEASE_FRAMES    = 2,
  parameter int FRAMES_PER_EIGHTH = 8,
  parameter int HOLD_W            = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pitch_valid,
  input  logic       pitch_present,
  input  logic [7:0] pitch_code,
  input  logic       flush,
  output logic [7:0] note,
  output logic [3:0] duration,
  output logic       note_dec,
  output logic       note_active
);

  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int MW = $clog2(RELEASE_FRAMES + 1);
  localparam int SH = $clog2(FRAMES_PER_EIGHTH);

  localparam logic [SW-1:0]     STAB_ONE  = SW'(1);
  localparam logic [SW-1:0]     STAB_LAST = SW'(STABLE_FRAMES - 1);
  localparam logic [MW-1:0]     MISS_LAST = MW'(RELEASE_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HELD_INIT = HOLD_W'(STABLE_FRAMES);
  localparam logic [HOLD_W-1:0] HELD_MAX  = '1;
  localparam logic [HOLD_W:0]   HALF_UNIT = (HOLD_W+1)'(FRAMES_PER_EIGHTH / 2);
  localparam logic [HOLD_W:0]   UNITS_2   = (HOLD_W+1)'(2);
  localparam logic [HOLD_W:0]   UNITS_4   = (HOLD_W+1)'(4);
  localparam logic [HOLD_W:0]   UNITS_8   = (HOLD_W+1)'(8);

  typedef enum logic [1:0] {IDLE, CAND, HOLD, EMIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cand_q, cand_d;
  logic [7:0]        cur_q, cur_d;
  logic [SW-1:0]     stab_q, stab_d;
  logic [MW-1:0]     miss_q, miss_d;
  logic [HOLD_W-1:0] held_q, held_d;
  logic [7:0]        note_q, note_d;
  logic [3:0]        duration_q, duration_d;
  logic              note_dec_q, note_dec_d;
  logic              note_active_q, note_active_d;
  logic              match_cand, match_cur;

  // One spare bit keeps the rounding add safe even when held has saturated.
  function automatic logic [3:0] quant(input logic [HOLD_W-1:0] held);
    logic [HOLD_W:0] units;
    units = ({1'b0, held} + HALF_UNIT) >> SH;
    if (units < UNITS_2)      quant = 4'b0001;
    else if (units < UNITS_4) quant = 4'b0010;
    else if (units < UNITS_8) quant = 4'b0100;
    else                      quant = 4'b1000;
  endfunction

  assign match_cand = pitch_present && (pitch_code == cand_q);
  assign match_cur  = pitch_present && (pitch_code == cur_q);

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cur_d      = cur_q;
    stab_d     = stab_q;
    miss_d     = miss_q;
    held_d     = held_q;
    note_d     = note_q;
    duration_d = duration_q;
    note_dec_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          stab_d = '0;
        end else if (pitch_valid && pitch_present) begin
          cand_d  = pitch_code;
          stab_d  = STAB_ONE;
          state_d = CAND;
        end
      end
      CAND: begin
        if (flush) begin
          stab_d  = '0;
          state_d = IDLE;
        end else if (pitch_valid) begin
          if (match_cand) begin
            if (stab_q == STAB_LAST) begin
              cur_d   = cand_q;
              held_d  = HELD_INIT;
              miss_d  = '0;
              stab_d  = '0;
              state_d = HOLD;
            end else begin
              stab_d = stab_q + STAB_ONE;
            end
          end else if (pitch_present) begin
            cand_d = pitch_code;
            stab_d = STAB_ONE;
          end else begin
            stab_d  = '0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = EMIT;
        end else if (pitch_valid) begin
          if (match_cur) begin
            if (held_q != HELD_MAX) held_d = held_q + 1'b1;
            miss_d = '0;
          end else if (miss_q == MISS_LAST) begin
            state_d = EMIT;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end
      EMIT: begin
        note_d     = cur_q;
        duration_d = quant(held_q);
        note_dec_d = 1'b1;
        held_d     = '0;
        miss_d     = '0;
        stab_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    note_active_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      stab_q        <= '0;
      miss_q        <= '0;
      held_q        <= '0;
      note_q        <= '0;
      duration_q    <= '0;
      note_dec_q    <= 1'b0;
      note_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stab_q        <= stab_d;
      miss_q        <= miss_d;
      held_q        <= held_d;
      note_q        <= note_d;
      duration_q    <= duration_d;
      note_dec_q    <= note_dec_d;
      note_active_q <= note_active_d;
    end
  end

  // Pitch codes are only consulted under the state, so they need no reset.
  always_ff @(posedge clk) begin
    cand_q <= cand_d;
    cur_q  <= cur_d;
  end

  assign note        = note_q;
  assign duration    = duration_q;
  assign note_dec    = note_dec_q;
  assign note_active = note_active_q;

endmodule

// File: tb/tb_note_segmenter.sv
// Directed bench for note_segmenter: one frame every 4 clocks, default parameters.
module tb_note_segmenter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pitch_valid = 1'b0;
  logic       pitch_present = 1'b0;
  logic [7:0] pitch_code = 8'h00;
  logic       flush = 1'b0;
  logic [7:0] note;
  logic [3:0] duration;
  logic       note_dec;
  logic       note_active;

  int checks = 0;
  int errors = 0;
  int dec_cnt = 0;
  int active_cnt = 0;
  logic [7:0] last_note = 8'h00;
  logic [3:0] last_dur = 4'h0;

  note_segmenter dut (
    .clk(clk), .reset(reset), .pitch_valid(pitch_valid),
    .pitch_present(pitch_present), .pitch_code(pitch_code), .flush(flush),
    .note(note), .duration(duration), .note_dec(note_dec), .note_active(note_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (note_dec) begin
      dec_cnt   <= dec_cnt + 1;
      last_note <= note;
      last_dur  <= duration;
    end
    if (note_active) active_cnt <= active_cnt + 1;
  end

  task automatic frame(input logic p, input logic [7:0] c);
    pitch_valid = 1'b1; pitch_present = p; pitch_code = c;
    @(negedge clk);
    pitch_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frames(input int n, input logic [7:0] c);
    for (int i = 0; i < n; i++) frame(1'b1, c);
  endtask

  task automatic test_reset();
    int d0;
    d0 = dec_cnt;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pitch_valid = $urandom_range(0, 1); pitch_present = $urandom_range(0, 1);
      pitch_code = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    pitch_valid = 1'b0;
    checks++; if (note !== 8'h00) begin errors++; $display("FAIL reset_note got %h exp 00", note); end
    checks++; if (duration !== 4'h0) begin errors++; $display("FAIL reset_dur got %b exp 0000", duration); end
    checks++; if (note_dec !== 1'b0) begin errors++; $display("FAIL reset_dec got %b exp 0", note_dec); end
    checks++; if (note_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", note_active); end
    checks++; if (dec_cnt != d0) begin errors++; $display("FAIL reset_no_emit got %0d exp %0d", dec_cnt - d0, 0); end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_quarter();
    int d0;
    d0 = dec_cnt;
    frames(16, 8'hC8);
    checks++; if (note_active !== 1'b1) begin errors++; $display("FAIL basic_active got %b exp 1", note_active); end
    frame(1'b0, 8'h00);
    pitch_valid = 1'b1; pitch_present = 1'b0;
    @(negedge clk);  // edge N sampled the releasing frame
    pitch_valid = 1'b0;
    checks++; if (note_dec !== 1'b0) begin errors++; $display("FAIL basic_dec_N got %b exp 0", note_dec); end
    @(negedge clk);
    checks++; if (note_dec !== 1'b1) begin errors++; $display("FAIL basic_dec_N1 got %b exp 1", note_dec); end
    checks++; if (note !== 8'hC8) begin errors++; $display("FAIL basic_note got %h exp c8", note); end
    checks++; if (duration !== 4'b0010) begin errors++; $display("FAIL basic_dur got %b exp 0010", duration); end
    @(negedge clk);
    checks++; if (note_dec !== 1'b0) begin errors++; $display("FAIL basic_dec_N2 got %b exp 0", note_dec); end
    repeat (4) @(negedge clk);
    checks++; if (dec_cnt - d0 != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", dec_cnt - d0); end
    checks++; if (note !== 8'hC8) begin errors++; $display("FAIL basic_note_hold got %h exp c8", note); end
  endtask

  task automatic test_short_onsets();
    int d0, a0;
    d0 = dec_cnt; a0 = active_cnt;
    frames(2, 8'hA8); frame(1'b0, 8'h00);
    frames(2, 8'hA8); frames(2, 8'hB8); frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (dec_cnt != d0) begin errors++; $display("FAIL short_no_emit got %0d exp 0", dec_cnt - d0); end
    checks++; if (active_cnt != a0) begin errors++; $display("FAIL short_no_active got %0d exp 0", active_cnt - a0); end
  endtask

  task automatic test_whole();
    int d0;
    d0 = dec_cnt;
    frames(100, 8'h88); frames(2, 8'h00);
    frame(1'b0, 8'h00);
    repeat (2) frame(1'b0, 8'h00);
    checks++; if (dec_cnt - d0 != 1) begin errors++; $display("FAIL whole_count got %0d exp 1", dec_cnt - d0); end
    checks++; if (last_note !== 8'h88 || last_dur !== 4'b1000) begin
      errors++; $display("FAIL whole_event got %h/%b exp 88/1000", last_note, last_dur); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = dec_cnt;
    frames(8, 8'hD8);
    frames(2, 8'hE8);
    repeat (2) @(negedge clk);
    checks++; if (dec_cnt - d0 != 1) begin errors++; $display("FAIL b2b_first_count got %0d exp 1", dec_cnt - d0); end
    checks++; if (last_note !== 8'hD8 || last_dur !== 4'b0001) begin
      errors++; $display("FAIL b2b_first got %h/%b exp d8/0001", last_note, last_dur); end
    frames(10, 8'hE8);
    frame(1'b0, 8'h00); frame(1'b0, 8'h00);
    checks++; if (dec_cnt - d0 != 2) begin errors++; $display("FAIL b2b_second_count got %0d exp 2", dec_cnt - d0); end
    checks++; if (last_note !== 8'hE8 || last_dur !== 4'b0001) begin
      errors++; $display("FAIL b2b_second got %h/%b exp e8/0001", last_note, last_dur); end
  endtask

  task automatic test_flush();
    int d0;
    d0 = dec_cnt;
    frames(33, 8'hF9);
    flush = 1'b1; pitch_valid = 1'b1; pitch_present = 1'b1; pitch_code = 8'hF9;
    @(negedge clk);
    flush = 1'b0; pitch_valid = 1'b0;
    @(negedge clk);
    checks++; if (note_dec !== 1'b1) begin errors++; $display("FAIL flush_dec got %b exp 1", note_dec); end
    checks++; if (note !== 8'hF9 || duration !== 4'b0100) begin
      errors++; $display("FAIL flush_event got %h/%b exp f9/0100", note, duration); end
    repeat (3) @(negedge clk);
    d0 = dec_cnt;
    frames(2, 8'hA8);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    frame(1'b1, 8'hA8);
    repeat (6) @(negedge clk);
    checks++; if (dec_cnt != d0 || note_active !== 1'b0) begin
      errors++; $display("FAIL flush_cand got %0d/%b exp 0/0", dec_cnt - d0, note_active); end
    frames(6, 8'hC8);
    checks++; if (note_active !== 1'b1) begin errors++; $display("FAIL midhold_active got %b exp 1", note_active); end
    reset = 1'b0; repeat (2) @(negedge clk); reset = 1'b1;
    frame(1'b0, 8'h00); frame(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (dec_cnt != d0) begin errors++; $display("FAIL midhold_no_emit got %0d exp 0", dec_cnt - d0); end
    checks++; if (note !== 8'h00 || duration !== 4'h0) begin
      errors++; $display("FAIL midhold_cleared got %h/%b exp 00/0000", note, duration); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_quarter();
    test_short_onsets();
    test_whole();
    test_back_to_back();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
